// File: rtl/mips_mmio_responder.sv
// MEM-stage memory-mapped I/O responder: PortOut register, synchronized PortIn
// with change detection, and a down-counting timer with interrupt.
module mips_mmio_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        Irq
);

  localparam logic [7:0] OFF_PORT_OUT    = 8'h24;
  localparam logic [7:0] OFF_PORT_IN     = 8'h28;
  localparam logic [7:0] OFF_STATUS      = 8'h2C;
  localparam logic [7:0] OFF_TIMER_LOAD  = 8'h30;
  localparam logic [7:0] OFF_TIMER_COUNT = 8'h34;
  localparam logic [7:0] OFF_TIMER_CTRL  = 8'h38;

  logic [31:0] portOutReg;
  logic [31:0] loadReg;
  logic [31:0] countReg;
  logic        ctrlEn, ctrlAuto, ctrlIrqEn;
  logic        inChanged, timerExpired;
  logic [SYNC_STAGES-1:0][7:0] syncReg;
  logic [7:0]  prevIn;
  logic [7:0]  syncOut;

  logic        inWindow;
  logic [7:0]  offset;
  logic        selPortOut, selPortIn, selStatus, selLoad, selCount, selCtrl;
  logic        wrPortOut, wrStatus, wrLoad, wrCtrl;
  logic        timerZero, expireEvt, changeEvt;
  logic [1:0]  w1cMask;

  assign offset   = Address[7:0];
  assign inWindow = (Address[31:8] == BASE_ADDR[31:8]) && (Address[1:0] == 2'b00);

  assign selPortOut = inWindow && (offset == OFF_PORT_OUT);
  assign selPortIn  = inWindow && (offset == OFF_PORT_IN);
  assign selStatus  = inWindow && (offset == OFF_STATUS);
  assign selLoad    = inWindow && (offset == OFF_TIMER_LOAD);
  assign selCount   = inWindow && (offset == OFF_TIMER_COUNT);
  assign selCtrl    = inWindow && (offset == OFF_TIMER_CTRL);

  assign Hit = selPortOut | selPortIn | selStatus | selLoad | selCount | selCtrl;

  assign wrPortOut = MemWrite && selPortOut;
  assign wrStatus  = MemWrite && selStatus;
  assign wrLoad    = MemWrite && selLoad;
  assign wrCtrl    = MemWrite && selCtrl;

  assign syncOut   = syncReg[SYNC_STAGES-1];
  assign changeEvt = (syncOut != prevIn);
  assign timerZero = (countReg == 32'd0);
  // A TIMER_LOAD write suppresses all timer activity for that edge.
  assign expireEvt = ctrlEn && !wrLoad && timerZero;
  assign w1cMask   = wrStatus ? WriteData[1:0] : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      portOutReg   <= '0;
      loadReg      <= '0;
      countReg     <= '0;
      ctrlEn       <= 1'b0;
      ctrlAuto     <= 1'b0;
      ctrlIrqEn    <= 1'b0;
      inChanged    <= 1'b0;
      timerExpired <= 1'b0;
      syncReg      <= '0;
      prevIn       <= '0;
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], PortIn};
      prevIn  <= syncOut;

      if (wrPortOut) portOutReg <= WriteData;

      if (wrLoad) begin
        loadReg  <= WriteData;
        countReg <= WriteData;
      end else if (ctrlEn) begin
        if (!timerZero)    countReg <= countReg - 32'd1;
        else if (ctrlAuto) countReg <= loadReg;
      end

      // A software write to TIMER_CTRL overrides the one-shot EN clear.
      if (wrCtrl) begin
        ctrlEn    <= WriteData[0];
        ctrlAuto  <= WriteData[1];
        ctrlIrqEn <= WriteData[2];
      end else if (expireEvt && !ctrlAuto) begin
        ctrlEn <= 1'b0;
      end

      // Hardware events win over a same-cycle W1C so no event is lost.
      inChanged    <= (inChanged & ~w1cMask[0]) | changeEvt;
      timerExpired <= (timerExpired & ~w1cMask[1]) | expireEvt;
    end
  end

  always_comb begin
    ReadData = 32'd0;
    if (MemRead) begin
      if (selPortOut) ReadData = portOutReg;
      if (selPortIn)  ReadData = {24'd0, syncOut};
      if (selStatus)  ReadData = {30'd0, timerExpired, inChanged};
      if (selLoad)    ReadData = loadReg;
      if (selCount)   ReadData = countReg;
      if (selCtrl)    ReadData = {29'd0, ctrlIrqEn, ctrlAuto, ctrlEn};
    end
  end

  assign PortOut = portOutReg;
  assign Irq     = timerExpired & ctrlIrqEn;

endmodule

// File: tb/tb_mips_mmio_responder.sv
// Bench for mips_mmio_responder: vector table, directed timer/reset sequences,
// then randomized traffic against a register-level reference model.
module tb_mips_mmio_responder;
  localparam logic [31:0] B  = 32'h1001_0000;
  localparam int          SS = 2;
  localparam logic [31:0] P  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset, MemRead, MemWrite, Hit, Irq;
  logic [31:0] Address, WriteData, ReadData, PortOut;
  logic [7:0]  PortIn;

  mips_mmio_responder #(.BASE_ADDR(B), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData), .Hit(Hit),
    .PortIn(PortIn), .PortOut(PortOut), .Irq(Irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int txn   = 0;
  bit modelOn = 1'b0;
  logic [31:0] sRd, sPort;
  logic        sHit, sIrq;

  // Reference model state, kept as plain register fields.
  logic [31:0] mPortOut, mLoad, mCount;
  logic        mEn, mAuto, mIrqEn, mInCh, mExp;
  logic [7:0]  mPrev;
  logic [7:0]  syncQ[$];

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [7:0]  pin;
    logic        hit;
    logic [31:0] rdata, port;
    logic        irq;
  } vec_t;

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] wd,
                              logic [7:0] pin, logic hit, logic [31:0] rdata,
                              logic [31:0] port, logic irq);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wd; v.pin = pin;
    v.hit = hit; v.rdata = rdata; v.port = port; v.irq = irq;
    return v;
  endfunction

  function automatic logic refHit(logic [31:0] a);
    return ((a & 32'hFFFF_FF00) == B) && (a[1:0] == 2'b00) &&
           (a[7:0] inside {8'h24, 8'h28, 8'h2C, 8'h30, 8'h34, 8'h38});
  endfunction

  function automatic logic [31:0] refRead(logic rd, logic [31:0] a);
    if (!(rd && refHit(a))) return 32'd0;
    case (a[7:0])
      8'h24:   return mPortOut;
      8'h28:   return {24'd0, syncQ[0]};
      8'h2C:   return {30'd0, mExp, mInCh};
      8'h30:   return mLoad;
      8'h34:   return mCount;
      default: return {29'd0, mIrqEn, mAuto, mEn};
    endcase
  endfunction

  task automatic modelReset();
    mPortOut = 0; mLoad = 0; mCount = 0;
    mEn = 0; mAuto = 0; mIrqEn = 0; mInCh = 0; mExp = 0; mPrev = 0;
    syncQ = {};
    for (int i = 0; i < SS; i++) syncQ.push_back(8'h00);
  endtask

  task automatic modelEdge(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [7:0] pin);
    logic        acc, loadWr, expEvt, chgEvt, nEn;
    logic [31:0] nCount;
    acc    = wr && refHit(a);
    loadWr = acc && (a[7:0] == 8'h30);
    expEvt = mEn && !loadWr && (mCount == 0);
    chgEvt = (syncQ[0] != mPrev);
    nCount = mCount;
    nEn    = mEn;
    if (mEn && !loadWr) begin
      if (mCount != 0) nCount = mCount - 1;
      else if (mAuto)  nCount = mLoad;
      else             nEn = 1'b0;
    end
    if (acc) begin
      case (a[7:0])
        8'h24: mPortOut = wd;
        8'h30: begin mLoad = wd; nCount = wd; end
        8'h38: begin nEn = wd[0]; mAuto = wd[1]; mIrqEn = wd[2]; end
        8'h2C: begin mInCh = mInCh & ~wd[0]; mExp = mExp & ~wd[1]; end
        default: ;
      endcase
    end
    mInCh  = mInCh | chgEvt;
    mExp   = mExp | expEvt;
    mCount = nCount;
    mEn    = nEn;
    mPrev  = syncQ[0];
    syncQ.push_back(pin);
    void'(syncQ.pop_front());
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one bus cycle, sample mid-cycle, then advance past the edge.
  task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [7:0] pin);
    MemRead = rd; MemWrite = wr; Address = a; WriteData = wd; PortIn = pin;
    #4;
    sRd = ReadData; sPort = PortOut; sHit = Hit; sIrq = Irq;
    if (modelOn) begin
      chk("rnd_hit", {31'd0, sHit}, {31'd0, refHit(a)});
      chk("rnd_rdata", sRd, refRead(rd, a));
      chk("rnd_portout", sPort, mPortOut);
      chk("rnd_irq", {31'd0, sIrq}, {31'd0, mExp & mIrqEn});
    end
    $display("txn %0d rd=%0b wr=%0b addr=%h wdata=%h pin=%h rdata=%h hit=%0b port=%h irq=%0b",
             txn, rd, wr, a, wd, pin, sRd, sHit, sPort, sIrq);
    txn++;
    @(posedge clk);
    modelEdge(wr, a, wd, pin);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    #2;
    chk("rst_rdata", ReadData, 32'd0);
    chk("rst_portout", PortOut, 32'd0);
    chk("rst_irq", {31'd0, Irq}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_rdata_hold", ReadData, 32'd0);
    modelReset();
    reset = 1'b0;
  endtask

  vec_t vecs[37];
  logic [7:0] offs[9];
  logic [31:0] seqCnt[6];

  initial begin
    vecs[0]  = mk(1, 0, B + 32'h26, 0, 8'h00, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, B + 32'h3C, 0, 8'h00, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, B + 32'h20, 0, 8'h00, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, B + 32'h24, P, 8'h00, 1, 0, 0, 0);
    vecs[4]  = mk(1, 0, B + 32'h24, 0, 8'h00, 1, P, P, 0);
    vecs[5]  = mk(0, 1, 32'h1000_0024, 32'h1234_5678, 8'h00, 0, 0, P, 0);
    vecs[6]  = mk(1, 0, B + 32'h24, 0, 8'h00, 1, P, P, 0);
    vecs[7]  = mk(0, 1, B + 32'h25, 0, 8'h00, 0, 0, P, 0);
    vecs[8]  = mk(1, 0, B + 32'h24, 0, 8'h00, 1, P, P, 0);
    vecs[9]  = mk(1, 0, B + 32'h28, 0, 8'hA5, 1, 0, P, 0);
    vecs[10] = mk(1, 0, B + 32'h28, 0, 8'hA5, 1, 0, P, 0);
    vecs[11] = mk(1, 0, B + 32'h2C, 0, 8'hA5, 1, 0, P, 0);
    vecs[12] = mk(1, 0, B + 32'h2C, 0, 8'hA5, 1, 1, P, 0);
    vecs[13] = mk(1, 0, B + 32'h28, 0, 8'hA5, 1, 32'hA5, P, 0);
    vecs[14] = mk(1, 1, B + 32'h2C, 1, 8'hA5, 1, 1, P, 0);
    vecs[15] = mk(1, 0, B + 32'h2C, 0, 8'hA5, 1, 0, P, 0);
    vecs[16] = mk(1, 0, B + 32'h2C, 0, 8'h3C, 1, 0, P, 0);
    vecs[17] = mk(1, 0, B + 32'h2C, 0, 8'h3C, 1, 0, P, 0);
    vecs[18] = mk(1, 0, B + 32'h2C, 0, 8'hC3, 1, 0, P, 0);
    vecs[19] = mk(1, 0, B + 32'h2C, 0, 8'hC3, 1, 1, P, 0);
    vecs[20] = mk(1, 1, B + 32'h2C, 1, 8'hC3, 1, 1, P, 0);
    vecs[21] = mk(1, 0, B + 32'h2C, 0, 8'hC3, 1, 1, P, 0);
    vecs[22] = mk(1, 1, B + 32'h2C, 1, 8'hC3, 1, 1, P, 0);
    vecs[23] = mk(1, 0, B + 32'h2C, 0, 8'hC3, 1, 0, P, 0);
    vecs[24] = mk(0, 1, B + 32'h30, 3, 8'hC3, 1, 0, P, 0);
    vecs[25] = mk(1, 0, B + 32'h34, 0, 8'hC3, 1, 3, P, 0);
    vecs[26] = mk(0, 1, B + 32'h38, 5, 8'hC3, 1, 0, P, 0);
    vecs[27] = mk(1, 0, B + 32'h34, 0, 8'hC3, 1, 3, P, 0);
    vecs[28] = mk(1, 0, B + 32'h34, 0, 8'hC3, 1, 2, P, 0);
    vecs[29] = mk(1, 0, B + 32'h34, 0, 8'hC3, 1, 1, P, 0);
    vecs[30] = mk(1, 0, B + 32'h34, 0, 8'hC3, 1, 0, P, 0);
    vecs[31] = mk(1, 0, B + 32'h2C, 0, 8'hC3, 1, 2, P, 1);
    vecs[32] = mk(1, 0, B + 32'h38, 0, 8'hC3, 1, 4, P, 1);
    vecs[33] = mk(1, 0, B + 32'h34, 0, 8'hC3, 1, 0, P, 1);
    vecs[34] = mk(0, 1, B + 32'h2C, 2, 8'hC3, 1, 0, P, 1);
    vecs[35] = mk(1, 0, B + 32'h2C, 0, 8'hC3, 1, 0, P, 0);
    vecs[36] = mk(1, 0, B + 32'h30, 0, 8'hC3, 1, 3, P, 0);

    MemRead = 1'b1; MemWrite = 1'b0; Address = B + 32'h24; WriteData = 0; PortIn = 0;
    doReset();

    for (int i = 0; i < 37; i++) begin
      step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].pin);
      chk($sformatf("vec%0d_hit", i), {31'd0, sHit}, {31'd0, vecs[i].hit});
      chk($sformatf("vec%0d_rdata", i), sRd, vecs[i].rdata);
      chk($sformatf("vec%0d_portout", i), sPort, vecs[i].port);
      chk($sformatf("vec%0d_irq", i), {31'd0, sIrq}, {31'd0, vecs[i].irq});
    end

    // Auto-reload: LOAD=2 gives a period of three edges.
    seqCnt = '{2, 1, 0, 2, 1, 0};
    step(0, 1, B + 32'h30, 2, 8'hC3);
    step(0, 1, B + 32'h38, 3, 8'hC3);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, B + 32'h34, 0, 8'hC3);
      chk($sformatf("auto_count%0d", i), sRd, seqCnt[i]);
    end
    step(1, 1, B + 32'h2C, 2, 8'hC3);
    chk("auto_status_set", sRd, 32'd2);
    step(1, 0, B + 32'h2C, 0, 8'hC3);
    chk("auto_status_cleared", sRd, 32'd0);
    step(1, 1, B + 32'h2C, 2, 8'hC3);
    chk("auto_w1c_race_pre", sRd, 32'd0);
    step(1, 0, B + 32'h2C, 0, 8'hC3);
    chk("auto_w1c_race_kept", sRd, 32'd2);

    // LOAD=0 with auto-reload expires on every edge.
    step(0, 1, B + 32'h30, 0, 8'hC3);
    step(0, 1, B + 32'h38, 7, 8'hC3);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, B + 32'h2C, 2, 8'hC3);
      chk($sformatf("load0_status%0d", i), sRd, 32'd2);
      chk($sformatf("load0_irq%0d", i), {31'd0, sIrq}, 32'd1);
    end
    step(1, 0, B + 32'h34, 0, 8'hC3);
    chk("load0_count", sRd, 32'd0);
    step(0, 1, B + 32'h38, 0, 8'hC3);
    step(0, 1, B + 32'h2C, 3, 8'hC3);
    step(1, 0, B + 32'h2C, 0, 8'hC3);
    chk("stop_status", sRd, 32'd0);
    chk("stop_irq", {31'd0, sIrq}, 32'd0);

    // Reset in the middle of a long count.
    step(0, 1, B + 32'h30, 100, 8'h00);
    step(0, 1, B + 32'h38, 7, 8'h00);
    for (int i = 0; i < 60; i++) step(1, 0, B + 32'h34, 0, 8'h00);
    step(1, 0, B + 32'h34, 0, 8'h00);
    chk("midrst_count40", sRd, 32'd40);
    chk("midrst_portout_pre", sPort, P);
    doReset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, B + 32'h34, 0, 8'h00);
      chk($sformatf("midrst_count_frozen%0d", i), sRd, 32'd0);
    end
    offs = '{8'h24, 8'h28, 8'h2C, 8'h30, 8'h38, 8'h24, 8'h24, 8'h24, 8'h24};
    for (int i = 0; i < 5; i++) begin
      step(1, 0, B | {24'd0, offs[i]}, 0, 8'h00);
      chk($sformatf("midrst_read_%h", offs[i]), sRd, 32'd0);
      chk($sformatf("midrst_irq%0d", i), {31'd0, sIrq}, 32'd0);
    end

    // Randomized traffic against the reference model.
    offs = '{8'h24, 8'h28, 8'h2C, 8'h30, 8'h34, 8'h38, 8'h3C, 8'h26, 8'h00};
    MemRead = 1'b0; MemWrite = 1'b0;
    doReset();
    modelOn = 1'b1;
    begin
      logic [7:0]  pinCur, off;
      logic [31:0] a, wd;
      logic        rd, wr;
      pinCur = 8'h00;
      for (int i = 0; i < 500; i++) begin
        rd  = ($urandom_range(0, 99) < 60);
        wr  = ($urandom_range(0, 99) < 35);
        off = offs[$urandom_range(0, 8)];
        a   = B | {24'd0, off};
        if ($urandom_range(0, 19) == 0) a = 32'h1000_0000 | {24'd0, off};
        wd  = $urandom;
        if (off == 8'h30) wd = $urandom_range(0, 6);
        if ($urandom_range(0, 7) == 0) pinCur = 8'($urandom);
        step(rd, wr, a, wd, pinCur);
      end
    end
    modelOn = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
